// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : FIFO-buffered, one-frame-at-a-time launcher for Tx_Top
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          flush,
  input  logic                          parity_en_cfg,
  input  logic                          tx_busy,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_parallel_data,
  output logic                          tx_parity_en,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] C_ZERO  = '0;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_full;
  logic                  r_empty;
  logic [1:0]            r_state;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_parity_en;

  logic                  w_wr_accept;
  logic                  w_pop;
  logic [LVL_W-1:0]      w_level_next;
  logic [1:0]            w_state_next;

  // Write acceptance looks only at the registered full flag, so a pop in the
  // same cycle cannot rescue a write aimed at a full FIFO.
  assign w_wr_accept = wr_en & ~r_full & ~flush;
  assign w_pop       = (r_state == S_IDLE) & ~r_empty & ~tx_busy & ~flush;

  always_comb begin
    w_level_next = r_level;
    if (flush) begin
      w_level_next = C_ZERO;
    end else if (w_wr_accept && !w_pop) begin
      w_level_next = r_level + LVL_W'(1);
    end else if (w_pop && !w_wr_accept) begin
      w_level_next = r_level - LVL_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop)    w_state_next = S_LAUNCH;
      S_LAUNCH:                  w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge UCLK) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_level <= w_level_next;
      r_full  <= (w_level_next == C_DEPTH);
      r_empty <= (w_level_next == C_ZERO);
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)       r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_data      <= '0;
      r_parity_en <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_valid    <= (r_state == S_LAUNCH);
      r_done     <= (r_state == S_WAIT_DONE) & ~tx_busy;
      r_overflow <= wr_en & r_full;
      // Data and parity setting are frozen from one pop to the next.
      if (w_pop) begin
        r_data      <= r_mem[r_rd_ptr];
        r_parity_en <= parity_en_cfg;
      end
    end
  end

  assign tx_data_valid    = r_valid;
  assign tx_parallel_data = r_data;
  assign tx_parity_en     = r_parity_en;
  assign fifo_full        = r_full;
  assign fifo_empty       = r_empty;
  assign fifo_level       = r_level;
  assign overflow         = r_overflow;
  assign tx_done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_scheduler : directed, table-driven and random checks
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          UCLK = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          flush;
  logic          parity_en_cfg;
  logic          tx_busy;
  logic          tx_data_valid;
  logic [DW-1:0] tx_parallel_data;
  logic          tx_parity_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          tx_done;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .UCLK             (UCLK),
    .reset            (reset),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .flush            (flush),
    .parity_en_cfg    (parity_en_cfg),
    .tx_busy          (tx_busy),
    .tx_data_valid    (tx_data_valid),
    .tx_parallel_data (tx_parallel_data),
    .tx_parity_en     (tx_parity_en),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .tx_done          (tx_done)
  );

  always #5 UCLK = ~UCLK;

  int total = 0;
  int bad   = 0;
  int busy_len = 0;
  int nvalid;
  int ndone;
  logic [DW-1:0] got[$];

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic [2:0]    lvl;
    logic          full;
    logic          empty;
    logic          ovf;
  } vec_t;
  vec_t tbl[6];

  // Reference model state: queue of held words plus the frame in flight.
  logic [DW-1:0] mq[$];
  logic          m_active, m_seen;
  int            m_age;
  logic          m_valid, m_done, m_ovf, m_par;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge UCLK);
    #1;
  endtask

  // Tx_Top stand-in: busy rises the cycle after data_valid and stays for len cycles.
  task automatic emu_busy(input int len);
    tx_busy = (busy_len > 0);
    if (busy_len > 0) busy_len--;
    if (tx_data_valid) begin
      busy_len = len;
      got.push_back(tx_parallel_data);
      nvalid++;
    end
  endtask

  task automatic emu_cycle(input int len);
    emu_busy(len);
    step();
  endtask

  task automatic model_edge();
    int  sz;
    logic acc, pop;
    sz      = mq.size();
    m_ovf   = wr_en && (sz == DEPTH);
    acc     = wr_en && (sz < DEPTH) && !flush;
    pop     = !m_active && (sz > 0) && !tx_busy && !flush;
    m_valid = m_active && (m_age == 0);
    m_done  = m_active && m_seen && !tx_busy;
    if (m_active) begin
      if (m_seen && !tx_busy) m_active = 1'b0;
      else if (m_age >= 1 && tx_busy) m_seen = 1'b1;
      m_age++;
    end
    if (pop) begin
      m_data   = mq.pop_front();
      m_par    = parity_en_cfg;
      m_active = 1'b1;
      m_age    = 0;
      m_seen   = 1'b0;
    end
    if (flush) mq.delete();
    else if (acc) mq.push_back(wr_data);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    parity_en_cfg = 1'b0; tx_busy = 1'b0;
    repeat (3) @(posedge UCLK);
    #1;
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full",  fifo_full, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_data",  tx_parallel_data, 0);
    reset = 1'b1;
    step();

    // Single word, parity off
    wr_en = 1'b1; wr_data = 8'hA5; parity_en_cfg = 1'b0;
    step();
    wr_en = 1'b0;
    chk("a_level1", fifo_level, 1);
    chk("a_novalid0", tx_data_valid, 0);
    step();
    chk("a_data", tx_parallel_data, 8'hA5);
    chk("a_par", tx_parity_en, 0);
    chk("a_empty_after_pop", fifo_empty, 1);
    chk("a_novalid1", tx_data_valid, 0);
    step();
    chk("a_valid", tx_data_valid, 1);
    step();
    tx_busy = 1'b1;
    nvalid = 0; ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nvalid += int'(tx_data_valid);
      ndone  += int'(tx_done);
    end
    chk("a_quiet_valid", nvalid, 0);
    chk("a_quiet_done", ndone, 0);
    tx_busy = 1'b0;
    step();
    chk("a_done", tx_done, 1);
    step();
    chk("a_done_pulse", tx_done, 0);
    chk("a_empty_end", fifo_empty, 1);

    // Fill and overflow with Tx_Top held busy
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].d;
      step();
      chk($sformatf("fill%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("fill%0d_full",  i), fifo_full,  tbl[i].full);
      chk($sformatf("fill%0d_empty", i), fifo_empty, tbl[i].empty);
      chk($sformatf("fill%0d_ovf",   i), overflow,   tbl[i].ovf);
    end
    wr_en = 1'b0;
    got.delete(); busy_len = 0; nvalid = 0;
    for (int i = 0; i < 60; i++) emu_cycle(3);
    chk("drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("drain%0d", i), got[i], i + 1);
    chk("drain_empty", fifo_empty, 1);

    // Simultaneous write and pop at level 2
    tx_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h11; step();
    wr_data = 8'h22; step();
    chk("c_level2", fifo_level, 2);
    wr_data = 8'h33; tx_busy = 1'b0;
    step();
    wr_en = 1'b0;
    chk("c_level_hold", fifo_level, 2);
    chk("c_head", tx_parallel_data, 8'h11);
    got.delete(); busy_len = 0;
    for (int i = 0; i < 50; i++) emu_cycle(2);
    chk("c_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("c_w0", got[0], 8'h11);
      chk("c_w1", got[1], 8'h22);
      chk("c_w2", got[2], 8'h33);
    end

    // Parity freeze across a configuration change
    parity_en_cfg = 1'b1; wr_en = 1'b1; wr_data = 8'h5A; tx_busy = 1'b0;
    step();
    wr_en = 1'b0;
    step();
    chk("d_par_pop", tx_parity_en, 1);
    chk("d_data", tx_parallel_data, 8'h5A);
    step();
    tx_busy = 1'b1;
    step();
    parity_en_cfg = 1'b0; wr_en = 1'b1; wr_data = 8'h6B;
    step();
    wr_en = 1'b0;
    step();
    chk("d_par_frozen", tx_parity_en, 1);
    tx_busy = 1'b0;
    step();
    chk("d_done", tx_done, 1);
    chk("d_par_after", tx_parity_en, 1);
    step();
    chk("d_par_next", tx_parity_en, 0);
    chk("d_data_next", tx_parallel_data, 8'h6B);
    busy_len = 0;
    for (int i = 0; i < 20; i++) emu_cycle(2);

    // Flush during a frame
    wr_en = 1'b1; wr_data = 8'h70; tx_busy = 1'b0;
    step();
    wr_en = 1'b0;
    step();
    step();
    tx_busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h71 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("e_level3", fifo_level, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("e_flush_level", fifo_level, 0);
    chk("e_flush_empty", fifo_empty, 1);
    tx_busy = 1'b0;
    step();
    chk("e_done", tx_done, 1);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nvalid += int'(tx_data_valid);
    end
    chk("e_no_launch", nvalid, 0);
    chk("e_level_end", fifo_level, 0);

    // Asynchronous reset mid-frame
    parity_en_cfg = 1'b1; wr_en = 1'b1; wr_data = 8'h81;
    step();
    wr_en = 1'b0;
    step();
    step();
    tx_busy = 1'b1; wr_en = 1'b1; wr_data = 8'h82;
    step();
    wr_en = 1'b0;
    chk("f_pre_level", fifo_level, 1);
    #2 reset = 1'b0;
    #1;
    chk("f_rst_data",  tx_parallel_data, 0);
    chk("f_rst_par",   tx_parity_en, 0);
    chk("f_rst_level", fifo_level, 0);
    chk("f_rst_empty", fifo_empty, 1);
    chk("f_rst_valid", tx_data_valid, 0);
    chk("f_rst_done",  tx_done, 0);
    #2 reset = 1'b1;
    tx_busy = 1'b0; parity_en_cfg = 1'b0;
    step();

    // Random traffic against the reference model
    mq.delete();
    m_active = 1'b0; m_seen = 1'b0; m_age = 0;
    m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_par = 1'b0; m_data = '0;
    busy_len = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk("r_valid", tx_data_valid, m_valid);
      chk("r_done",  tx_done, m_done);
      chk("r_ovf",   overflow, m_ovf);
      chk("r_level", fifo_level, mq.size());
      chk("r_full",  fifo_full, mq.size() == DEPTH);
      chk("r_empty", fifo_empty, mq.size() == 0);
      chk("r_data",  tx_parallel_data, m_data);
      chk("r_par",   tx_parity_en, m_par);
      emu_busy($urandom_range(1, 6));
      wr_en         = 1'($urandom_range(0, 1));
      wr_data       = 8'($urandom);
      flush         = ($urandom_range(0, 39) == 0);
      parity_en_cfg = 1'($urandom_range(0, 1));
      model_edge();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit-side scheduler that sits between the APB register interface and `Tx_Top`. It buffers bytes written by the bus in a small FIFO and launches one UART frame at a time: it presents the byte on `parallel_data`, pulses `data_valid`, then tracks `busy` until the frame completes. It also freezes the parity-enable setting for the duration of each frame, so that a configuration change mid-frame cannot corrupt the frame on the line.

## Interface
- DATA_WIDTH, 8, width of one UART data word
- FIFO_DEPTH, 4, number of buffered words; must be a power of two and ≥ 2
- UCLK  input  1  UART clock; all logic is rising-edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe from the bus side; one word per cycle
- wr_data  input  DATA_WIDTH  word to enqueue
- flush  input  1  synchronous FIFO clear; does not affect the frame in flight
- parity_en_cfg  input  1  parity-enable setting from the configuration register
- tx_busy  input  1  `busy` from `Tx_Top`
- tx_data_valid  output  1  drives `Tx_Top` `data_valid`; one-cycle pulse
- tx_parallel_data  output  DATA_WIDTH  drives `Tx_Top` `parallel_data`; registered
- tx_parity_en  output  1  drives `Tx_Top` `parity_en`; registered and frame-stable
- fifo_full  output  1  level == FIFO_DEPTH
- fifo_empty  output  1  level == 0
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words currently held
- overflow  output  1  one-cycle pulse when a write is dropped
- tx_done  output  1  one-cycle pulse when a frame completes

## Operation
- FIFO is circular, with rd_ptr and wr_ptr of width $clog2(FIFO_DEPTH). Both pointers wrap modulo FIFO_DEPTH.
- Write rule: a write is accepted when wr_en=1 and fifo_full=0, using the registered value of full.
  - A write while full is dropped and overflow=1 for that cycle, even if a pop occurs in the same cycle.
- Level update per cycle: +1 on accepted write only; −1 on pop only; unchanged when both occur.
- Flush: flush=1 sets both pointers and level to 0 on that edge and overrides any write or pop in the same cycle. The FSM is unaffected.
- The FSM has four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: when fifo_empty=0, tx_busy=0 and flush=0:
  - pop the head word into tx_parallel_data;
  - latch parity_en_cfg into tx_parity_en;
  - go to LAUNCH.
- LAUNCH: tx_data_valid=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0. On that edge, pulse tx_done for one cycle and go to IDLE.
- tx_parallel_data and tx_parity_en change only on a pop. They hold their values through the whole frame and after it.
- parity_en_cfg changes outside IDLE take effect only on the next pop.

## Timing
- Reset (async assert): both pointers 0, fifo_level=0, state=IDLE. All outputs are 0, except fifo_empty=1.
- Reset asserted mid-frame: stored words are lost and no tx_done is produced. `Tx_Top` shares the same reset and aborts its frame as well.
- Write-to-launch latency with FIFO empty, state IDLE and tx_busy=0:
  - write at edge N;
  - fifo_level=1 after edge N;
  - pop at edge N+1;
  - tx_data_valid high for the cycle after edge N+2.
- Back-to-back frames: the next pop occurs at the first edge where state=IDLE and tx_busy=0. This gives at least 1 idle cycle between tx_done and the next tx_data_valid.
- Full/empty flags and fifo_level are registered and update on the edge after the causing event.
- WAIT_BUSY has no timeout: a `Tx_Top` that never raises busy leaves the scheduler stalled until reset.

## Test plan
- Single word, parity off: write 0xA5 with tx_busy modelled as 10 cycles high starting 1 cycle after tx_data_valid.
  - Required: tx_parallel_data=0xA5, tx_parity_en=0, one tx_data_valid pulse 2 cycles after the write, tx_done on the busy fall, fifo_empty=1 at the end.
- Fill and overflow, FIFO_DEPTH=4 with tx_busy held at 1: write 0x01..0x05.
  - Required: fifo_full=1 after the 4th write, overflow pulses on the 5th write, fifo_level=4.
  - On release of tx_busy, words drain in order 0x01..0x04 and 0x05 is never sent.
- Simultaneous write and pop at level 2: required level stays 2.
  - Pointer wrap check: 10 words streamed with occasional stalls arrive at `Tx_Top` in order with no loss.
- Parity freeze: pop with parity_en_cfg=1, then toggle it to 0 during WAIT_DONE.
  - Required: tx_parity_en stays 1 until the next pop, then becomes 0.
- Flush and reset: flush with 3 words queued during a frame.
  - Required: the current frame completes with tx_done, no further tx_data_valid, fifo_level=0.
  - Assert reset mid-frame: all outputs return to their reset values immediately, asynchronously to UCLK.
